// File: rtl/camera_dvp_tx.sv
// DVP-style camera stream transmitter: 16-bit pixels sent as MSB/LSB byte pairs, framed by
// vsync/hsync with programmable blanking. Also acts as a colour-bar / ramp pattern generator.
module camera_dvp_tx #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  s_cam_clk_dft,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [15:0]           cfg_cols_i,
  input  logic [15:0]           cfg_rows_i,
  input  logic [15:0]           cfg_hblank_i,
  input  logic [7:0]            cfg_vsync_w_i,
  input  logic [15:0]           cfg_vbp_i,
  input  logic [15:0]           cfg_vfp_i,
  input  logic [1:0]            cfg_pattern_i,
  input  logic [15:0]           pix_data_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [DATA_WIDTH-1:0] cam_data_o,
  output logic                  cam_hsync_o,
  output logic                  cam_vsync_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  underrun_o,
  input  logic                  underrun_clr_i
);

  // state  | meaning
  // IDLE   | waiting for cfg_en_i
  // VSYNC  | vsync high, W cycles
  // VBP    | vertical back porch, skipped when 0
  // ACTIVE | hsync high, two bytes per pixel
  // HBLANK | hsync low between lines
  // VFP    | vertical front porch, skipped when 0
  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] col, col_nxt;
  logic [15:0] row, row_nxt;
  logic        phase, phase_nxt;
  logic        start, frame_end;

  logic [15:0] sh_cols, sh_rows, sh_hblank, sh_vbp, sh_vfp;
  logic [1:0]  sh_pattern;

  logic        hold_valid;
  logic [15:0] hold_data;
  logic [7:0]  lsb_q;
  logic [7:0]  data_q;

  logic        busy, stream_mode;
  logic        msb_load, consume, underrun_set;
  logic        vsync_d, hsync_d;
  logic [7:0]  byte_d;
  logic [15:0] pat_pix, pix_sel;

  assign busy        = (state != S_IDLE);
  assign stream_mode = (sh_pattern == 2'd0);

  always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      col          <= '0;
      row          <= '0;
      phase        <= 1'b0;
      sh_cols      <= '0;
      sh_rows      <= '0;
      sh_hblank    <= '0;
      sh_vbp       <= '0;
      sh_vfp       <= '0;
      sh_pattern   <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      lsb_q        <= '0;
      data_q       <= '0;
      cam_hsync_o  <= 1'b0;
      cam_vsync_o  <= 1'b0;
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      phase <= phase_nxt;
      if (start) begin
        sh_cols    <= cfg_cols_i;
        sh_rows    <= cfg_rows_i;
        sh_hblank  <= cfg_hblank_i;
        sh_vbp     <= cfg_vbp_i;
        sh_vfp     <= cfg_vfp_i;
        sh_pattern <= cfg_pattern_i;
      end
      if (pix_valid_i && pix_ready_o) begin
        hold_data  <= pix_data_i;
        hold_valid <= 1'b1;
      end else if (consume) begin
        hold_valid <= 1'b0;
      end
      if (msb_load) lsb_q <= pix_sel[7:0];
      data_q       <= byte_d;
      cam_vsync_o  <= vsync_d;
      cam_hsync_o  <= hsync_d;
      frame_done_o <= frame_end;
      if (underrun_set)        underrun_o <= 1'b1;
      else if (underrun_clr_i) underrun_o <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = col;
    row_nxt   = row;
    phase_nxt = phase;
    start     = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: if (cfg_en_i) start = 1'b1;
      S_VSYNC: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (sh_vbp != 16'd0) begin
          state_nxt = S_VBP;
          cnt_nxt   = sh_vbp - 16'd1;
        end else begin
          state_nxt = S_ACTIVE;
          col_nxt   = '0;
          phase_nxt = 1'b0;
        end
      end
      S_VBP: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else begin
          state_nxt = S_ACTIVE;
          col_nxt   = '0;
          phase_nxt = 1'b0;
        end
      end
      S_ACTIVE: begin
        // equality compares only, so C/R of 0xFFFF never wrap the counters
        if (!phase) begin
          phase_nxt = 1'b1;
        end else if (col != sh_cols) begin
          col_nxt   = col + 16'd1;
          phase_nxt = 1'b0;
        end else if (row != sh_rows) begin
          state_nxt = S_HBLANK;
          cnt_nxt   = (sh_hblank == 16'd0) ? 16'd0 : sh_hblank - 16'd1;
        end else if (sh_vfp != 16'd0) begin
          state_nxt = S_VFP;
          cnt_nxt   = sh_vfp - 16'd1;
        end else begin
          frame_end = 1'b1;
        end
      end
      S_HBLANK: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else begin
          state_nxt = S_ACTIVE;
          col_nxt   = '0;
          phase_nxt = 1'b0;
          row_nxt   = row + 16'd1;
        end
      end
      S_VFP: begin
        if (cnt != 16'd0) cnt_nxt = cnt - 16'd1;
        else              frame_end = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (frame_end) begin
      if (cfg_en_i) start = 1'b1;
      else          state_nxt = S_IDLE;
    end
    if (start) begin
      state_nxt = S_VSYNC;
      cnt_nxt   = (cfg_vsync_w_i == 8'd0) ? 16'd0 : {8'd0, cfg_vsync_w_i - 8'd1};
      row_nxt   = '0;
    end
  end

  always_comb begin
    case (col_nxt[6:4])
      3'd0:    pat_pix = 16'hFFFF;
      3'd1:    pat_pix = 16'hFFE0;
      3'd2:    pat_pix = 16'h07FF;
      3'd3:    pat_pix = 16'h07E0;
      3'd4:    pat_pix = 16'hF81F;
      3'd5:    pat_pix = 16'hF800;
      3'd6:    pat_pix = 16'h001F;
      default: pat_pix = 16'h0000;
    endcase
    if (sh_pattern[1]) pat_pix = {row_nxt[7:0], col_nxt[7:0]};
    pix_sel = pat_pix;
    if (stream_mode) pix_sel = hold_valid ? hold_data : 16'h0000;

    // outputs are registered, so they are decoded from the next-cycle position
    msb_load     = (state_nxt == S_ACTIVE) && !phase_nxt;
    consume      = msb_load && stream_mode && hold_valid;
    underrun_set = msb_load && stream_mode && !hold_valid;
    vsync_d      = (state_nxt == S_VSYNC);
    hsync_d      = (state_nxt == S_ACTIVE);
    byte_d       = 8'h00;
    if (hsync_d) byte_d = phase_nxt ? lsb_q : pix_sel[15:8];
    pix_ready_o  = stream_mode && ((busy && !hold_valid) || consume);
  end

  assign cam_data_o = DATA_WIDTH'(data_q);
  assign busy_o     = busy;

endmodule

// File: tb/tb_camera_dvp_tx.sv
// Bench for camera_dvp_tx: frame timing from the closed-form cycle formulas, pixel stream
// from a queue of accepted words, randomized configs and source stalls.
module tb_camera_dvp_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_cols = '0, cfg_rows = '0, cfg_hblank = '0, cfg_vbp = '0, cfg_vfp = '0;
  logic [7:0]  cfg_vsync_w = '0;
  logic [1:0]  cfg_pattern = '0;
  logic [15:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [11:0] cam_data;
  logic        cam_hsync, cam_vsync, frame_done, busy, underrun;
  logic        underrun_clr = 1'b0;

  camera_dvp_tx #(.DATA_WIDTH(12)) dut (
    .s_cam_clk_dft (clk),
    .rstn_i        (rstn),
    .cfg_en_i      (cfg_en),
    .cfg_cols_i    (cfg_cols),
    .cfg_rows_i    (cfg_rows),
    .cfg_hblank_i  (cfg_hblank),
    .cfg_vsync_w_i (cfg_vsync_w),
    .cfg_vbp_i     (cfg_vbp),
    .cfg_vfp_i     (cfg_vfp),
    .cfg_pattern_i (cfg_pattern),
    .pix_data_i    (pix_data),
    .pix_valid_i   (pix_valid),
    .pix_ready_o   (pix_ready),
    .cam_data_o    (cam_data),
    .cam_hsync_o   (cam_hsync),
    .cam_vsync_o   (cam_vsync),
    .frame_done_o  (frame_done),
    .busy_o        (busy),
    .underrun_o    (underrun),
    .underrun_clr_i(underrun_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // test parameters
  int p_c, p_r, p_h, p_w, p_vbp, p_vfp, p_pat, p_vpct;
  // reference model state
  logic [15:0] q[$];
  logic [15:0] src_list[$];
  logic [15:0] cur_pix = '0;
  bit          m_under = 0;

  function automatic logic [15:0] pat_pixel(input int pat, input int row, input int col);
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    if (pat == 1) return bars[(col / 16) % 8];
    return 16'(((row % 256) * 256) + (col % 256));
  endfunction

  // drive source/clear inputs for this cycle, check ready, advance model across the edge
  task automatic drive_and_model(input bit busy_exp, input bit msb_next, input int nrow, input int ncol);
    bit rdy_exp, set_u;
    pix_valid    = ($urandom_range(0, 99) < p_vpct);
    pix_data     = (src_list.size() > 0) ? src_list[0] : 16'($urandom);
    underrun_clr = ($urandom_range(0, 15) == 0);
    rdy_exp = busy_exp && (p_pat == 0) && (q.size() == 0 || msb_next);
    #1;
    check_val("pix_ready", 32'(pix_ready), 32'(rdy_exp));
    set_u = 0;
    if (msb_next) begin
      if (p_pat != 0) cur_pix = pat_pixel(p_pat, nrow, ncol);
      else if (q.size() > 0) cur_pix = q.pop_front();
      else begin cur_pix = 16'h0000; set_u = 1; end
    end
    if (pix_valid && rdy_exp) begin
      q.push_back(pix_data);
      if (src_list.size() > 0) void'(src_list.pop_front());
    end
    if (set_u) m_under = 1;
    else if (underrun_clr) m_under = 0;
  endtask

  task automatic idle_step(input string tag, input bit done_exp);
    @(negedge clk);
    check_val({tag, "_vsync"}, 32'(cam_vsync), 32'd0);
    check_val({tag, "_hsync"}, 32'(cam_hsync), 32'd0);
    check_val({tag, "_data"}, 32'(cam_data), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(frame_done), 32'(done_exp));
    check_val({tag, "_underrun"}, 32'(underrun), 32'(m_under));
    drive_and_model(1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_stream(input string tag, input int nframes, input bit abort);
    int wq, hq, len, per, s0, tt, k, off, nk, noff;
    bit act, nact;
    wq = (p_w == 0) ? 1 : p_w;
    hq = (p_h == 0) ? 1 : p_h;
    len = 2 * (p_c + 1);
    per = len + hq;
    s0 = wq + p_vbp;
    tt = s0 + (p_r + 1) * len + p_r * hq + p_vfp;
    idle_step({tag, "_pre"}, 1'b0);
    cfg_cols = 16'(p_c); cfg_rows = 16'(p_r); cfg_hblank = 16'(p_h);
    cfg_vsync_w = 8'(p_w); cfg_vbp = 16'(p_vbp); cfg_vfp = 16'(p_vfp);
    cfg_pattern = 2'(p_pat);
    cfg_en = 1'b1;
    for (int f = 0; f < nframes; f++) begin
      for (int t = 0; t < tt; t++) begin
        @(negedge clk);
        if (abort && t == s0 + 1) begin
          rstn = 1'b0;
          #1;
          check_val("rst_hsync", 32'(cam_hsync), 32'd0);
          check_val("rst_vsync", 32'(cam_vsync), 32'd0);
          check_val("rst_data", 32'(cam_data), 32'd0);
          check_val("rst_done", 32'(frame_done), 32'd0);
          check_val("rst_busy", 32'(busy), 32'd0);
          check_val("rst_underrun", 32'(underrun), 32'd0);
          check_val("rst_ready", 32'(pix_ready), 32'd0);
          q.delete();
          m_under = 0;
          cfg_en = 1'b0;
          @(negedge clk);
          rstn = 1'b1;
          for (int i = 0; i < 4; i++) idle_step("post_rst", 1'b0);
          return;
        end
        act = 0; k = 0; off = 0;
        if (t >= s0) begin
          k = (t - s0) / per; off = (t - s0) % per;
          act = (k <= p_r) && (off < len);
        end
        check_val({tag, "_vsync"}, 32'(cam_vsync), 32'(t < wq));
        check_val({tag, "_hsync"}, 32'(cam_hsync), 32'(act));
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_done"}, 32'(frame_done), 32'(t == 0 && f > 0));
        check_val({tag, "_underrun"}, 32'(underrun), 32'(m_under));
        if (!act) check_val({tag, "_data_blank"}, 32'(cam_data), 32'd0);
        else if (off % 2 == 0) check_val({tag, "_data_msb"}, 32'(cam_data), 32'(cur_pix[15:8]));
        else check_val({tag, "_data_lsb"}, 32'(cam_data), 32'(cur_pix[7:0]));
        if (f == nframes - 1 && t == 0) begin
          // mid-frame disable and config garbage must not disturb this frame
          cfg_en = 1'b0;
          cfg_cols = 16'($urandom); cfg_rows = 16'($urandom); cfg_hblank = 16'($urandom);
          cfg_vsync_w = 8'($urandom); cfg_vbp = 16'($urandom); cfg_vfp = 16'($urandom);
          cfg_pattern = 2'($urandom);
        end
        nact = 0; nk = 0; noff = 0;
        if (t + 1 < tt && t + 1 >= s0) begin
          nk = (t + 1 - s0) / per; noff = (t + 1 - s0) % per;
          nact = (nk <= p_r) && (noff < len);
        end
        drive_and_model(1'b1, nact && (noff % 2 == 0), nk, noff / 2);
      end
    end
    idle_step({tag, "_end"}, 1'b1);
    idle_step({tag, "_after"}, 1'b0);
  endtask

  task automatic set_cfg(input int c, r, h, w, vbp, vfp, pat, vpct);
    p_c = c; p_r = r; p_h = h; p_w = w; p_vbp = vbp; p_vfp = vfp; p_pat = pat; p_vpct = vpct;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    set_cfg(1, 1, 2, 2, 1, 1, 2, 50);
    run_stream("b2b", 3, 1'b0);
    set_cfg(3, 0, 1, 1, 0, 0, 0, 100);
    src_list = '{16'h1234, 16'hABCD, 16'h00FF, 16'hF00F};
    run_stream("stream", 1, 1'b0);
    src_list.delete();
    set_cfg(3, 1, 2, 1, 1, 1, 0, 40);
    run_stream("underrun", 2, 1'b0);
    set_cfg(127, 0, 1, 1, 0, 0, 1, 50);
    run_stream("bars", 1, 1'b0);
    set_cfg(15, 3, 3, 2, 2, 2, 2, 50);
    run_stream("ramp", 1, 1'b0);
    set_cfg(2, 2, 0, 0, 0, 0, 0, 70);
    run_stream("zeros", 2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(30, 100));
      run_stream("rand", $urandom_range(1, 3), 1'b0);
    end
    set_cfg(3, 2, 1, 1, 1, 1, 0, 80);
    run_stream("abort", 1, 1'b1);
    set_cfg(1, 1, 1, 1, 0, 1, 0, 90);
    run_stream("recover", 2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
